// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-step shift/rotate controller around a 1-bit-per-cycle
// shifter. It accepts one request (operand, type, amount) on a valid/ready
// handshake. It applies one step per clock until the amount is used up. It
// then holds the result on an output valid/ready handshake.
//
// Parameters:
//   WIDTH  operand/result width (>= 2)
//   AMT_W  shift-amount width (amounts 0 .. 2**AMT_W-1)
// Ports:
//   clk, rst_n  clock; asynchronous active-low reset
//   in_valid    request present
//   in_ready    block can accept a request
//   in_data     operand
//   in_type     [0] 1=right/0=left, [1] 1=logical/0=arithmetic (right shift
//               only), [2] 1=rotate/0=shift
//   in_amt      number of 1-bit steps
//   out_valid   result present
//   out_ready   consumer takes result
//   out_data    result (equals the work register in every state)
//   busy        high while shifting or holding a result
// Configuration macro:
//   SHIFT_SEQ_PIPE_EN  when defined, a new request is accepted on the same edge
//                      that completes the output handshake (no IDLE bubble).

module shift_sequencer #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned AMT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [2:0]       in_type,
  input  logic [AMT_W-1:0] in_amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [WIDTH-1:0]   work_q;
  logic [2:0]         type_q;
  logic [AMT_W-1:0]   count_q;
  logic [WIDTH-1:0]   step_val;
  logic               accept;
  state_t             load_state;

  assign accept     = in_valid && in_ready;
  // A zero-amount request skips SHIFT entirely.
  assign load_state = (in_amt == AMT_W'(0)) ? DONE : SHIFT;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. Acceptance in DONE can only happen when the pipelined
  // in_ready is enabled, so this block serves both builds.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = load_state;
      end
      SHIFT: begin
        if (count_q == AMT_W'(1)) state_d = DONE;
      end
      DONE: begin
        if (accept)         state_d = load_state;
        else if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode from the state register.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
      end
      SHIFT: begin
        busy = 1'b1;
      end
      DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
`ifdef SHIFT_SEQ_PIPE_EN
        in_ready  = out_ready;
`else
        in_ready  = 1'b0;
`endif
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  // Single-step shifter on the work register, selected by the captured type.
  always_comb begin
    step_val = work_q;
    if (type_q[2]) begin
      if (type_q[0]) step_val = {work_q[0], work_q[WIDTH-1:1]};
      else           step_val = {work_q[WIDTH-2:0], work_q[WIDTH-1]};
    end else begin
      if (!type_q[0])     step_val = {work_q[WIDTH-2:0], 1'b0};
      else if (type_q[1]) step_val = {1'b0, work_q[WIDTH-1:1]};
      else                step_val = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
    end
  end

  // Datapath: load on accept, step and count down while in SHIFT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_q  <= '0;
      type_q  <= '0;
      count_q <= '0;
    end else if (accept) begin
      work_q  <= in_data;
      type_q  <= in_type;
      count_q <= in_amt;
    end else if (state_q == SHIFT) begin
      work_q  <= step_val;
      count_q <= count_q - AMT_W'(1);
    end
  end

  assign out_data = work_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer (WIDTH=4, AMT_W=3): a vector table of
// single requests, followed by hand-written multi-cycle sequences.

module tb_shift_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic [2:0] in_type;
  logic [2:0] in_amt;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic       busy;

  int checks = 0;
  int passed = 0;

  shift_sequencer #(.WIDTH(4), .AMT_W(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_type   (in_type),
    .in_amt    (in_amt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] data;
    logic [2:0] typ;
    logic [2:0] amt;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete request: accept, count latency, check result, take it.
  task automatic run_vec(input string name, input logic [3:0] d, input logic [2:0] t,
                         input logic [2:0] a, input logic [3:0] e);
    int lat;
    check({name, " in_ready"}, 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    in_data   = d;
    in_type   = t;
    in_amt    = a;
    out_ready = 1'b0;
    tick();
    // Disturb inputs after acceptance; they must be ignored.
    in_valid = 1'b0;
    in_data  = ~d;
    in_type  = ~t;
    in_amt   = 3'd7;
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    check({name, " latency"}, 32'(lat), 32'(a));
    check({name, " data"}, 32'(out_data), 32'(e));
    check({name, " busy"}, 32'(busy), 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({name, " out_valid clr"}, 32'(out_valid), 32'd0);
    check({name, " idle ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    // data, type, amt, expected
    vecs[0]  = '{4'b1001, 3'b001, 3'd2, 4'b1110}; // arith right 2
    vecs[1]  = '{4'b1001, 3'b011, 3'd1, 4'b0100}; // logical right 1
    vecs[2]  = '{4'b1001, 3'b000, 3'd7, 4'b0000}; // left 7 saturates
    vecs[3]  = '{4'b1001, 3'b100, 3'd5, 4'b0011}; // rotate left 5
    vecs[4]  = '{4'b1001, 3'b101, 3'd4, 4'b1001}; // rotate right 4 wraps
    vecs[5]  = '{4'b0110, 3'b000, 3'd0, 4'b0110}; // amount 0
    vecs[6]  = '{4'b1001, 3'b001, 3'd7, 4'b1111}; // arith right saturates to sign
    vecs[7]  = '{4'b1001, 3'b011, 3'd7, 4'b0000}; // logical right saturates
    vecs[8]  = '{4'b1001, 3'b111, 3'd1, 4'b1100}; // rotate right, bit1 ignored
    vecs[9]  = '{4'b1001, 3'b010, 3'd1, 4'b0010}; // left, bit1 ignored
    vecs[10] = '{4'b0110, 3'b110, 3'd3, 4'b0011}; // rotate left 3, bit1 ignored
    vecs[11] = '{4'b0101, 3'b001, 3'd1, 4'b0010}; // arith right positive

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 4'h0;
    in_type   = 3'b000;
    in_amt    = 3'd0;
    out_ready = 1'b0;
    #12;
    check("rst in_ready", 32'(in_ready), 32'd1);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst out_data", 32'(out_data), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 12; i++)
      run_vec($sformatf("vec%0d", i), vecs[i].data, vecs[i].typ, vecs[i].amt, vecs[i].exp);

    // Amount 0 with the consumer stalled; in_valid pulses in DONE are ignored.
    in_valid = 1'b1; in_data = 4'b0110; in_type = 3'b000; in_amt = 3'd0; out_ready = 1'b0;
    tick();
    check("hold valid0", 32'(out_valid), 32'd1);
    check("hold data0", 32'(out_data), 32'h6);
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_data = 4'b1111; in_amt = 3'd0;
      tick();
      check($sformatf("hold valid%0d", k + 1), 32'(out_valid), 32'd1);
      check($sformatf("hold data%0d", k + 1), 32'(out_data), 32'h6);
      check($sformatf("hold ready%0d", k + 1), 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("hold released", 32'(out_valid), 32'd0);
    check("hold idle", 32'(in_ready), 32'd1);
    tick();
    check("hold no queued", 32'(out_valid), 32'd0);
    check("hold no busy", 32'(busy), 32'd0);

    // Reset in the middle of an amount-6 job.
    in_valid = 1'b1; in_data = 4'b1001; in_type = 3'b101; in_amt = 3'd6;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("pre-rst busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid-rst out_valid", 32'(out_valid), 32'd0);
    check("mid-rst in_ready", 32'(in_ready), 32'd1);
    check("mid-rst busy", 32'(busy), 32'd0);
    check("mid-rst out_data", 32'(out_data), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post-rst out_valid", 32'(out_valid), 32'd0);
    run_vec("post-rst", 4'b1001, 3'b001, 3'd2, 4'b1110);

    // Back-to-back requests with the consumer always ready.
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 4'b1001; in_type = 3'b001; in_amt = 3'd1;
    tick();
    in_data = 4'b0110; in_type = 3'b011; in_amt = 3'd1;
    tick();
    check("b2b A valid", 32'(out_valid), 32'd1);
    check("b2b A data", 32'(out_data), 32'hc);
`ifdef SHIFT_SEQ_PIPE_EN
    check("b2b ready in DONE", 32'(in_ready), 32'd1);
    tick();
    check("b2b no bubble busy", 32'(busy), 32'd1);
    check("b2b no bubble ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
`else
    check("b2b ready in DONE", 32'(in_ready), 32'd0);
    tick();
    check("b2b bubble busy", 32'(busy), 32'd0);
    check("b2b bubble ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check("b2b B busy", 32'(busy), 32'd1);
`endif
    check("b2b B shifting", 32'(out_valid), 32'd0);
    tick();
    check("b2b B valid", 32'(out_valid), 32'd1);
    check("b2b B data", 32'(out_data), 32'h3);
    tick();
    out_ready = 1'b0;
    check("b2b end idle", 32'(in_ready), 32'd1);
    check("b2b end valid", 32'(out_valid), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Multi-bit shift controller built around the team's single-step shifter operation set: logical/arithmetic shift and rotate, left or right. Accepts one request (operand, 3-bit type, shift amount) over a valid/ready handshake and applies one 1-bit step per clock until the amount is exhausted. Presents the result on an output valid/ready handshake. Sits between an issuing unit (decoder/ALU sequencer) and the consumer of shift results; trades latency for a minimal single-step datapath.

## Interface
- WIDTH, 4: operand/result width in bits; minimum 2.
- AMT_W, 3: shift-amount width; amounts 0..2^AMT_W-1.
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  request present.
- in_ready  output  1  block can accept a request.
- in_data  input  WIDTH  operand.
- in_type  input  3  [0] 1=right / 0=left; [1] 1=logical / 0=arithmetic (right only); [2] 1=rotate / 0=shift.
- in_amt  input  AMT_W  number of 1-bit steps.
- out_valid  output  1  result present.
- out_ready  input  1  consumer takes result.
- out_data  output  WIDTH  result.
- busy  output  1  high in SHIFT or DONE.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: in_ready=1. Accept on edge with in_valid&&in_ready. Capture in_data into work reg, in_type into type reg, in_amt into count. Next state is DONE if in_amt==0, else SHIFT.
- Inputs are sampled only at acceptance; later changes are ignored. in_valid while not ready is ignored, not queued.
- SHIFT: each edge applies one step to the work reg and decrements count. On the edge where count==1, go to DONE.
- Step function, by captured type:
  - rotate right: {w[0], w[W-1:1]}.
  - rotate left: {w[W-2:0], w[W-1]}.
  - shift left: {w[W-2:0], 0}. type[1] is ignored.
  - logical right: {0, w[W-1:1]}.
  - arithmetic right: {w[W-1], w[W-1:1]}.
  - type[1] is ignored when type[2]=1.
- Amounts ≥WIDTH are legal. Stepping continues, so:
  - shifts saturate to all-zero (left, logical right) or all-sign (arithmetic right).
  - rotates wrap modulo WIDTH.
- DONE: out_valid=1 and out_data=work reg, held stable until the edge with out_ready=1, then go to IDLE.
- out_data equals the work reg in all states. It is meaningful only while out_valid=1.

## Timing
- Reset (async assert, sync release) values: state=IDLE, in_ready=1, out_valid=0, busy=0, out_data=0, count=0.
- Latency: out_valid rises after the amt-th edge following the accept edge (amt=0: immediately after the accept edge).
- A request of amount N occupies the block for N+1 cycles plus the cycles out_ready stays low.
- in_ready, out_valid and busy decode directly from the state register; there is no combinational path from in_valid to in_ready.
- Throughput without the macro: at most one request per N+2 cycles (one IDLE cycle between jobs).
- Reset asserted mid-SHIFT or mid-DONE: the job is discarded immediately, all outputs return to reset values, and no result is produced.

## Configuration
- SHIFT_SEQ_PIPE_EN defined:
  - in_ready = IDLE || (DONE && out_ready).
  - An edge that completes the output handshake and sees in_valid captures the new request directly, entering SHIFT or DONE per its amount, with no IDLE bubble.
  - out_data changes only after that edge.
- Undefined: in_ready = IDLE only, as described above.

## Test plan
- WIDTH=4, in_data=4'b1001, type=3'b001, amt=2 → out_data=4'b1110; out_valid 2 edges after accept.
- in_data=4'b1001, type=3'b011, amt=1 → 4'b0100. type=3'b000, amt=7 → 4'b0000 after 7 steps.
- in_data=4'b1001, type=3'b100, amt=5 → 4'b0011. type=3'b101, amt=4 → 4'b1001.
- amt=0, in_data=4'b0110 → out_valid directly after accept edge, out_data=4'b0110. Hold out_ready=0 for 3 cycles → out_data stable, in_ready=0; in_valid pulses during DONE are ignored.
- Assert rst_n=0 during SHIFT of an amt=6 job → out_valid=0, in_ready=1, busy=0 immediately; new request after release completes correctly.
- With SHIFT_SEQ_PIPE_EN: back-to-back requests with out_ready=1 and in_valid=1 → second accept on the same edge as the first result handshake; with the macro undefined, one IDLE cycle occurs between them.
